apb_irq_ctrl: RTL and testbench
===============================

# apb_irq_ctrl

APB-slave interrupt controller that arbitrates the SoC's 11 peripheral interrupt sources (Timer[3:0], SPI, I2C0/1, UART0/1, GPIO0/1) onto a single CPU interrupt request with a claim/complete handshake. It sits on one APB slot behind the AXI2APB bridge, next to the other peripherals in `perip_top`. It takes the SoC interrupt vector and drives `irq_o` and `irq_id_o` toward `cpu_top`. It applies fixed priority, per-source enable and per-source edge/level mode, and allows one interrupt in service at a time.

## Interface
- `NUM_IRQ`, default 11: number of sources; source i is bit i of `irq_i`; a higher index has higher priority.
- `APB_SLAVE_ADDR_WIDTH`, default 12: PADDR width; only PADDR[4:2] is decoded.
- `BUS_DATA_WIDTH`, default 32: APB data width.
- `PCLK` input 1: the single clock. All state is on its rising edge.
- `PRESETn` input 1: asynchronous, active-low reset.
- `PSEL` input 1: APB select.
- `PENABLE` input 1: APB access phase.
- `PADDR` input `APB_SLAVE_ADDR_WIDTH`: byte address.
- `PWRITE` input 1: 1 = write.
- `PWDATA` input `BUS_DATA_WIDTH`: write data.
- `PRDATA` output `BUS_DATA_WIDTH`: read data; 0 when not in a read access phase.
- `PREADY` output 1: constant 1 (zero wait states).
- `PSLVERR` output 1: error flag, valid during the access phase.
- `irq_i` input `NUM_IRQ`: raw sources, synchronous to PCLK.
- `irq_o` output 1: registered CPU interrupt request.
- `irq_id_o` output `$clog2(NUM_IRQ+1)`: registered (highest pending-enabled index + 1); 0 when there is none.

## Operation
- Register map (word offsets):
  - 0x00 PENDING: RO.
  - 0x04 ENABLE: RW, reset 0.
  - 0x08 MODE: RW, reset 0. 1 = rising-edge, 0 = level.
  - 0x0C PEND_CLR: WO, write-1-to-clear. Clears edge-mode pending bits only.
  - 0x10 CLAIM: RO with side effect.
  - 0x14 COMPLETE: WO.
  - 0x18 STATUS: RO. bit0 = in_service; bits[7:4] = in-service ID.
  - Unused bits read as 0.
- Edge detect: `irq_prev <= irq_i` each cycle; reset value 0. A rising edge is `irq_i & ~irq_prev`.
- Pending bit i:
  - Level mode: a registered copy of `irq_i[i]`.
  - Edge mode: sticky. It is set on a rising edge and cleared by a CLAIM of i or by PEND_CLR.
  - When a set and a clear of the same bit occur in the same cycle, the set wins.
- Candidate = `pending & ENABLE`. The winner is the highest set index; its ID is index+1.
- FSM with states IDLE and SERVICE. Reset state is IDLE.
- IDLE:
  - A CLAIM read returns the current candidate ID (0 if none).
  - If the ID is nonzero: latch it as svc_id, clear the edge pending bit for that source, and go to SERVICE.
  - A CLAIM that returns 0 has no side effect.
- SERVICE:
  - `irq_o` is forced to 0.
  - CLAIM reads return 0 with no side effect.
  - A COMPLETE write where PWDATA[3:0] == svc_id returns to IDLE.
  - A COMPLETE write with a mismatched ID is ignored and raises PSLVERR.
- A COMPLETE write in IDLE is ignored and raises PSLVERR.
- An access to an unmapped offset (≥0x1C), or a write to a read-only register, raises PSLVERR; it has no effect and reads return 0.
- A level source that is still high after COMPLETE re-requests the interrupt.
- Writes to ENABLE or MODE take effect on the next cycle's candidate.

## Timing
- Reset values: all registers 0, `irq_prev` 0, FSM in IDLE, `irq_o` 0, `irq_id_o` 0, `PRDATA` 0, `PSLVERR` 0, `PREADY` 1.
- A source already high when reset is released is seen as a rising edge on the first clock.
- Latency:
  - `irq_i[i]` is sampled high at edge k and pending is set after edge k.
  - `irq_o` and `irq_id_o` update after edge k+1.
  - Total: 2 cycles from source to CPU.
- APB access:
  - The side effects of CLAIM and COMPLETE, and all register writes, commit at the rising edge that ends the access phase (PSEL & PENABLE).
  - PRDATA and PSLVERR are combinational during the access phase.
- The CLAIM read value uses the candidate from the same cycle, not the registered `irq_id_o`.
- After a CLAIM, `irq_o` is 0 on the next cycle.
- After a COMPLETE, `irq_o` reflects the candidate one cycle later.
- Reset asserted mid-service: returns asynchronously to IDLE, and all pending and in-service state is lost.

## Test plan
- Edge and priority: set ENABLE=0x7FF and MODE=0x7FF, pulse `irq_i[3]` and `irq_i[9]` for 1 cycle → PENDING=0x208 and `irq_o`=1 two cycles later with `irq_id_o`=10. CLAIM → 10, PENDING=0x008, STATUS=0xA1. COMPLETE 10 → `irq_o`=1 with `irq_id_o`=4 one cycle later.
- Level re-request: ENABLE bit5 set, MODE=0, hold `irq_i[5]` high. CLAIM → 6. COMPLETE 6 while `irq_i[5]` is still high → `irq_o` reasserts with `irq_id_o`=6. Drop `irq_i[5]` → `irq_o`=0 two cycles later.
- Masking: pend source 7 with ENABLE=0 → `irq_o` stays 0 and CLAIM returns 0 (STATUS=0). Set ENABLE bit7 → `irq_o`=1 with `irq_id_o`=8 after one cycle.
- Errors: COMPLETE 3 in IDLE, COMPLETE 5 while in service on 8, access to 0x1C, write to 0x00 → PSLVERR=1 each time, with no state change and PREADY=1 throughout.
- Simultaneous events: in edge mode, a new rising edge on source 2 in the same cycle as a CLAIM of 3 (ID=3) → the pending bit stays set. A PEND_CLR of bit 2 coinciding with a new edge → the bit stays set.
- Reset mid-service: assert PRESETn low in SERVICE while ENABLE=0x7FF → all outputs 0 and STATUS=0 immediately. After release, a source held high → `irq_o`=1 after 2 cycles once ENABLE has been reprogrammed.

Source files
------------

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: fixed-priority arbitration of NUM_IRQ sources onto one
// CPU request, with per-source enable, edge/level mode and a claim/complete handshake.
module apb_irq_ctrl #(
    parameter int NUM_IRQ              = 11,
    parameter int APB_SLAVE_ADDR_WIDTH = 12,
    parameter int BUS_DATA_WIDTH       = 32
) (
    input  logic                               PCLK,
    input  logic                               PRESETn,
    input  logic                               PSEL,
    input  logic                               PENABLE,
    input  logic [APB_SLAVE_ADDR_WIDTH-1:0]    PADDR,
    input  logic                               PWRITE,
    input  logic [BUS_DATA_WIDTH-1:0]          PWDATA,
    output logic [BUS_DATA_WIDTH-1:0]          PRDATA,
    output logic                               PREADY,
    output logic                               PSLVERR,
    input  logic [NUM_IRQ-1:0]                 irq_i,
    output logic                               irq_o,
    output logic [$clog2(NUM_IRQ+1)-1:0]       irq_id_o
);
    localparam int ID_W = $clog2(NUM_IRQ + 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_SERVICE = 1'b1;

    localparam logic [2:0] A_PENDING  = 3'd0;
    localparam logic [2:0] A_ENABLE   = 3'd1;
    localparam logic [2:0] A_MODE     = 3'd2;
    localparam logic [2:0] A_PEND_CLR = 3'd3;
    localparam logic [2:0] A_CLAIM    = 3'd4;
    localparam logic [2:0] A_COMPLETE = 3'd5;
    localparam logic [2:0] A_STATUS   = 3'd6;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nx;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_cand;
    logic [NUM_IRQ-1:0] w_claim_mask;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_pending_nx;
    logic [ID_W-1:0]    r_svc_id;
    logic [ID_W-1:0]    r_irq_id;
    logic [ID_W-1:0]    w_cand_id;
    logic               r_irq;
    logic [2:0]         w_idx;
    logic               w_acc;
    logic               w_rd;
    logic               w_wr;
    logic               w_in_svc;
    logic               w_claim;
    logic               w_complete_ok;
    logic               w_err;
    logic               w_unused;

    assign w_acc    = PSEL & PENABLE;
    assign w_wr     = w_acc & PWRITE;
    assign w_rd     = w_acc & ~PWRITE;
    assign w_idx    = PADDR[4:2];
    assign w_in_svc = (r_state == S_SERVICE);
    assign w_unused = ^{PADDR[APB_SLAVE_ADDR_WIDTH-1:5], PADDR[1:0],
                        PWDATA[BUS_DATA_WIDTH-1:NUM_IRQ]};

    assign w_rise = irq_i & ~r_irq_prev;
    assign w_cand = r_pending & r_enable;

    // Ascending scan so the highest set index is the one left standing.
    always_comb begin
        w_cand_id = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_cand[i]) w_cand_id = ID_W'(i + 1);
        end
    end

    assign w_claim       = w_rd && (w_idx == A_CLAIM) && !w_in_svc && (w_cand_id != '0);
    assign w_complete_ok = w_wr && (w_idx == A_COMPLETE) && w_in_svc &&
                           (PWDATA[ID_W-1:0] == r_svc_id);

    always_comb begin
        w_claim_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_claim && (w_cand_id == ID_W'(i + 1))) w_claim_mask[i] = 1'b1;
        end
    end

    assign w_clr = w_claim_mask |
                   ((w_wr && (w_idx == A_PEND_CLR)) ? PWDATA[NUM_IRQ-1:0] : '0);

    // Edge bits are sticky with set-over-clear; level bits simply track the source.
    assign w_pending_nx = (r_mode & (w_rise | (r_pending & ~w_clr))) | (~r_mode & irq_i);

    always_comb begin
        w_state_nx = r_state;
        if (w_claim)            w_state_nx = S_SERVICE;
        else if (w_complete_ok) w_state_nx = S_IDLE;
    end

    always_comb begin
        w_err = 1'b0;
        if (w_acc) begin
            case (w_idx)
                A_PENDING, A_CLAIM, A_STATUS: w_err = PWRITE;
                A_COMPLETE:                   w_err = PWRITE & ~w_complete_ok;
                A_ENABLE, A_MODE, A_PEND_CLR: w_err = 1'b0;
                default:                      w_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        PRDATA = '0;
        if (w_rd) begin
            case (w_idx)
                A_PENDING: PRDATA[NUM_IRQ-1:0] = r_pending;
                A_ENABLE:  PRDATA[NUM_IRQ-1:0] = r_enable;
                A_MODE:    PRDATA[NUM_IRQ-1:0] = r_mode;
                A_CLAIM:   PRDATA[ID_W-1:0]    = w_in_svc ? '0 : w_cand_id;
                A_STATUS: begin
                    PRDATA[0]         = w_in_svc;
                    PRDATA[4 +: ID_W] = r_svc_id;
                end
                default:   PRDATA = '0;
            endcase
        end
    end

    assign PREADY   = 1'b1;
    assign PSLVERR  = w_err;
    assign irq_o    = r_irq;
    assign irq_id_o = r_irq_id;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= S_IDLE;
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_enable   <= '0;
            r_mode     <= '0;
            r_svc_id   <= '0;
            r_irq      <= 1'b0;
            r_irq_id   <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_irq_prev <= irq_i;
            r_pending  <= w_pending_nx;
            if (w_wr && (w_idx == A_ENABLE)) r_enable <= PWDATA[NUM_IRQ-1:0];
            if (w_wr && (w_idx == A_MODE))   r_mode   <= PWDATA[NUM_IRQ-1:0];
            if (w_claim)            r_svc_id <= w_cand_id;
            else if (w_complete_ok) r_svc_id <= '0;
            // The request drops in the same edge that enters SERVICE.
            r_irq    <= (w_state_nx == S_IDLE) && (w_cand_id != '0);
            r_irq_id <= w_cand_id;
        end
    end
endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Directed bench for apb_irq_ctrl: one task per scenario, inline checks against
// hand-computed values, single summary line at the end.
module tb_apb_irq_ctrl;
    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic [11:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [10:0] irq_i;
    logic        irq_o;
    logic [3:0]  irq_id_o;

    logic [31:0] rd_data;
    logic        last_err;
    logic        last_ready;
    int          n_checks;
    int          n_pass;

    apb_irq_ctrl dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .irq_i    (irq_i),
        .irq_o    (irq_o),
        .irq_id_o (irq_id_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // pulse: sources raised for exactly the commit edge of the access
    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [10:0] pulse);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1; irq_i = irq_i | pulse;
        #1;
        last_err = PSLVERR; last_ready = PREADY;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; irq_i = irq_i & ~pulse;
    endtask

    task automatic apb_read(input logic [11:0] addr, input logic [10:0] pulse);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(negedge PCLK);
        PENABLE = 1'b1; irq_i = irq_i | pulse;
        #1;
        rd_data = PRDATA; last_err = PSLVERR; last_ready = PREADY;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; irq_i = irq_i & ~pulse;
    endtask

    task automatic test_reset;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0;
        PWDATA = '0; irq_i = '0;
        repeat (2) @(negedge PCLK);
        n_checks++; if (irq_o !== 1'b0) $display("FAIL reset_irq_o: got %b want 0", irq_o); else n_pass++;
        n_checks++; if (irq_id_o !== 4'd0) $display("FAIL reset_irq_id: got %0d want 0", irq_id_o); else n_pass++;
        n_checks++; if (PREADY !== 1'b1) $display("FAIL reset_pready: got %b want 1", PREADY); else n_pass++;
        n_checks++; if (PSLVERR !== 1'b0) $display("FAIL reset_pslverr: got %b want 0", PSLVERR); else n_pass++;
        n_checks++; if (PRDATA !== 32'h0) $display("FAIL reset_prdata: got %h want 0", PRDATA); else n_pass++;
        PRESETn = 1'b1;
        apb_read(12'h004, '0);
        n_checks++; if (rd_data !== 32'h0) $display("FAIL reset_enable: got %h want 0", rd_data); else n_pass++;
        apb_read(12'h008, '0);
        n_checks++; if (rd_data !== 32'h0) $display("FAIL reset_mode: got %h want 0", rd_data); else n_pass++;
        apb_read(12'h018, '0);
        n_checks++; if (rd_data !== 32'h0) $display("FAIL reset_status: got %h want 0", rd_data); else n_pass++;
    endtask

    task automatic test_edge_priority;
        apb_write(12'h004, 32'h7FF, '0);
        apb_write(12'h008, 32'h7FF, '0);
        @(negedge PCLK); irq_i = 11'h208;
        @(negedge PCLK); irq_i = '0;
        n_checks++; if (irq_o !== 1'b0) $display("FAIL edge_latency1: got %b want 0", irq_o); else n_pass++;
        @(negedge PCLK);
        n_checks++; if (irq_o !== 1'b1) $display("FAIL edge_irq: got %b want 1", irq_o); else n_pass++;
        n_checks++; if (irq_id_o !== 4'd10) $display("FAIL edge_id: got %0d want 10", irq_id_o); else n_pass++;
        apb_read(12'h000, '0);
        n_checks++; if (rd_data !== 32'h208) $display("FAIL edge_pending: got %h want 208", rd_data); else n_pass++;
        apb_read(12'h010, '0);
        n_checks++; if (rd_data !== 32'd10) $display("FAIL edge_claim: got %0d want 10", rd_data); else n_pass++;
        n_checks++; if (irq_o !== 1'b0) $display("FAIL edge_claim_irq: got %b want 0", irq_o); else n_pass++;
        apb_read(12'h000, '0);
        n_checks++; if (rd_data !== 32'h008) $display("FAIL edge_pending2: got %h want 008", rd_data); else n_pass++;
        apb_read(12'h018, '0);
        n_checks++; if (rd_data !== 32'hA1) $display("FAIL edge_status: got %h want a1", rd_data); else n_pass++;
        apb_write(12'h014, 32'd10, '0);
        n_checks++; if (last_err !== 1'b0) $display("FAIL edge_complete_err: got %b want 0", last_err); else n_pass++;
        n_checks++; if (irq_o !== 1'b1) $display("FAIL edge_next_irq: got %b want 1", irq_o); else n_pass++;
        n_checks++; if (irq_id_o !== 4'd4) $display("FAIL edge_next_id: got %0d want 4", irq_id_o); else n_pass++;
        apb_read(12'h010, '0);
        n_checks++; if (rd_data !== 32'd4) $display("FAIL edge_claim4: got %0d want 4", rd_data); else n_pass++;
        apb_write(12'h014, 32'd4, '0);
        apb_read(12'h018, '0);
        n_checks++; if (rd_data !== 32'h0) $display("FAIL edge_status_idle: got %h want 0", rd_data); else n_pass++;
    endtask

    task automatic test_level;
        apb_write(12'h008, 32'h0, '0);
        apb_write(12'h004, 32'h020, '0);
        n_checks++; if (PRDATA !== 32'h0) $display("FAIL level_prdata_idle: got %h want 0", PRDATA); else n_pass++;
        @(negedge PCLK); irq_i[5] = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        n_checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd6)
            $display("FAIL level_irq: got %b/%0d want 1/6", irq_o, irq_id_o); else n_pass++;
        apb_read(12'h010, '0);
        n_checks++; if (rd_data !== 32'd6) $display("FAIL level_claim: got %0d want 6", rd_data); else n_pass++;
        n_checks++; if (irq_o !== 1'b0) $display("FAIL level_claim_irq: got %b want 0", irq_o); else n_pass++;
        apb_write(12'h014, 32'd6, '0);
        n_checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd6)
            $display("FAIL level_rerequest: got %b/%0d want 1/6", irq_o, irq_id_o); else n_pass++;
        @(negedge PCLK); irq_i[5] = 1'b0;
        @(negedge PCLK);
        n_checks++; if (irq_o !== 1'b1) $display("FAIL level_drop1: got %b want 1", irq_o); else n_pass++;
        @(negedge PCLK);
        n_checks++; if (irq_o !== 1'b0) $display("FAIL level_drop2: got %b want 0", irq_o); else n_pass++;
    endtask

    task automatic test_masking;
        apb_write(12'h004, 32'h0, '0);
        apb_write(12'h008, 32'h080, '0);
        @(negedge PCLK); irq_i[7] = 1'b1;
        @(negedge PCLK); irq_i[7] = 1'b0;
        @(negedge PCLK);
        n_checks++; if (irq_o !== 1'b0) $display("FAIL mask_irq: got %b want 0", irq_o); else n_pass++;
        apb_read(12'h010, '0);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL mask_claim: got %0d want 0", rd_data); else n_pass++;
        apb_read(12'h018, '0);
        n_checks++; if (rd_data !== 32'h0) $display("FAIL mask_status: got %h want 0", rd_data); else n_pass++;
        apb_read(12'h000, '0);
        n_checks++; if (rd_data !== 32'h080) $display("FAIL mask_pending: got %h want 080", rd_data); else n_pass++;
        apb_write(12'h004, 32'h080, '0);
        n_checks++; if (irq_o !== 1'b0) $display("FAIL mask_enable0: got %b want 0", irq_o); else n_pass++;
        @(negedge PCLK);
        n_checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd8)
            $display("FAIL mask_enable1: got %b/%0d want 1/8", irq_o, irq_id_o); else n_pass++;
    endtask

    task automatic test_errors;
        apb_write(12'h014, 32'd3, '0);
        n_checks++; if (last_err !== 1'b1) $display("FAIL err_complete_idle: got %b want 1", last_err); else n_pass++;
        n_checks++; if (last_ready !== 1'b1) $display("FAIL err_ready1: got %b want 1", last_ready); else n_pass++;
        n_checks++; if (irq_o !== 1'b1) $display("FAIL err_irq_kept: got %b want 1", irq_o); else n_pass++;
        apb_read(12'h010, '0);
        n_checks++; if (rd_data !== 32'd8) $display("FAIL err_claim8: got %0d want 8", rd_data); else n_pass++;
        apb_write(12'h014, 32'd5, '0);
        n_checks++; if (last_err !== 1'b1) $display("FAIL err_complete_bad: got %b want 1", last_err); else n_pass++;
        apb_read(12'h018, '0);
        n_checks++; if (rd_data !== 32'h81) $display("FAIL err_status_svc: got %h want 81", rd_data); else n_pass++;
        apb_read(12'h01C, '0);
        n_checks++; if (last_err !== 1'b1 || rd_data !== 32'h0)
            $display("FAIL err_read_unmapped: got %b/%h want 1/0", last_err, rd_data); else n_pass++;
        apb_write(12'h01C, 32'hFFFF, '0);
        n_checks++; if (last_err !== 1'b1) $display("FAIL err_write_unmapped: got %b want 1", last_err); else n_pass++;
        apb_write(12'h000, 32'hFFFF, '0);
        n_checks++; if (last_err !== 1'b1) $display("FAIL err_write_ro: got %b want 1", last_err); else n_pass++;
        n_checks++; if (last_ready !== 1'b1) $display("FAIL err_ready2: got %b want 1", last_ready); else n_pass++;
        apb_write(12'h010, 32'h0, '0);
        n_checks++; if (last_err !== 1'b1) $display("FAIL err_write_claim: got %b want 1", last_err); else n_pass++;
        apb_read(12'h018, '0);
        n_checks++; if (rd_data !== 32'h81) $display("FAIL err_status_kept: got %h want 81", rd_data); else n_pass++;
        apb_read(12'h000, '0);
        n_checks++; if (rd_data !== 32'h0) $display("FAIL err_pending: got %h want 0", rd_data); else n_pass++;
        apb_read(12'h004, '0);
        n_checks++; if (rd_data !== 32'h080) $display("FAIL err_enable_kept: got %h want 080", rd_data); else n_pass++;
        apb_write(12'h014, 32'd8, '0);
        n_checks++; if (last_err !== 1'b0) $display("FAIL err_complete_ok: got %b want 0", last_err); else n_pass++;
        apb_read(12'h018, '0);
        n_checks++; if (rd_data !== 32'h0) $display("FAIL err_status_idle: got %h want 0", rd_data); else n_pass++;
    endtask

    task automatic test_back_to_back;
        apb_write(12'h008, 32'h004, '0);
        apb_write(12'h004, 32'h004, '0);
        @(negedge PCLK); irq_i[2] = 1'b1;
        @(negedge PCLK); irq_i[2] = 1'b0;
        @(negedge PCLK);
        n_checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd3)
            $display("FAIL sim_irq: got %b/%0d want 1/3", irq_o, irq_id_o); else n_pass++;
        apb_read(12'h010, 11'h004);
        n_checks++; if (rd_data !== 32'd3) $display("FAIL sim_claim: got %0d want 3", rd_data); else n_pass++;
        apb_read(12'h018, '0);
        n_checks++; if (rd_data !== 32'h31) $display("FAIL sim_status: got %h want 31", rd_data); else n_pass++;
        apb_read(12'h000, '0);
        n_checks++; if (rd_data !== 32'h004) $display("FAIL sim_claim_set_wins: got %h want 004", rd_data); else n_pass++;
        apb_write(12'h014, 32'd3, '0);
        n_checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd3)
            $display("FAIL sim_rerequest: got %b/%0d want 1/3", irq_o, irq_id_o); else n_pass++;
        apb_write(12'h00C, 32'h004, 11'h004);
        apb_read(12'h000, '0);
        n_checks++; if (rd_data !== 32'h004) $display("FAIL sim_clr_set_wins: got %h want 004", rd_data); else n_pass++;
        apb_write(12'h00C, 32'h004, '0);
        apb_read(12'h000, '0);
        n_checks++; if (rd_data !== 32'h0) $display("FAIL sim_clr: got %h want 0", rd_data); else n_pass++;
    endtask

    task automatic test_reset_mid_service;
        apb_write(12'h004, 32'h7FF, '0);
        apb_write(12'h008, 32'h7FF, '0);
        @(negedge PCLK); irq_i[0] = 1'b1;
        @(negedge PCLK); irq_i[0] = 1'b0;
        apb_read(12'h010, '0);
        n_checks++; if (rd_data !== 32'd1) $display("FAIL rst_claim: got %0d want 1", rd_data); else n_pass++;
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        n_checks++; if (irq_o !== 1'b0 || irq_id_o !== 4'd0)
            $display("FAIL rst_outputs: got %b/%0d want 0/0", irq_o, irq_id_o); else n_pass++;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'h018; irq_i[4] = 1'b1;
        #1;
        n_checks++; if (PRDATA !== 32'h0 || PSLVERR !== 1'b0)
            $display("FAIL rst_status: got %h/%b want 0/0", PRDATA, PSLVERR); else n_pass++;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK); PRESETn = 1'b1;
        apb_read(12'h004, '0);
        n_checks++; if (rd_data !== 32'h0) $display("FAIL rst_enable: got %h want 0", rd_data); else n_pass++;
        n_checks++; if (irq_o !== 1'b0) $display("FAIL rst_irq_masked: got %b want 0", irq_o); else n_pass++;
        apb_write(12'h004, 32'h010, '0);
        n_checks++; if (irq_o !== 1'b0) $display("FAIL rst_reprog0: got %b want 0", irq_o); else n_pass++;
        @(negedge PCLK);
        n_checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd5)
            $display("FAIL rst_reprog1: got %b/%0d want 1/5", irq_o, irq_id_o); else n_pass++;
        irq_i = '0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_edge_priority();
        test_level();
        test_masking();
        test_errors();
        test_back_to_back();
        test_reset_mid_service();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
